data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 11, data-memory address width (matches CPU DataAddr).
REQ-002 Parameter DATA_W, 16, data word width (matches CPU In_Data/Out_Data).
REQ-003 Parameter HOST_MAX_WAIT, 8, consecutive host wait cycles before forced host grant (range 1..255).
REQ-004 Clock  in  1  single clock; all state updates on rising edge.
REQ-005 Reset  in  1  asynchronous, active-high reset.
REQ-006 CpuRd  in  1  CPU read request, same cycle as CpuAddr.
REQ-007 CpuWr  in  1  CPU write request, same cycle as CpuAddr/CpuWrData.
REQ-008 CpuAddr  in  ADDR_W  CPU data address.
REQ-009 CpuWrData  in  DATA_W  CPU write data.
REQ-010 CpuRdData  out  DATA_W  CPU read data, valid when CpuRdValid=1.
REQ-011 CpuRdValid  out  1  one-cycle pulse, cycle after a granted CPU read.
REQ-012 CpuStall  out  1  CPU request present but not granted this cycle.
REQ-013 HostReq  in  1  host (debug/loader) request, held until HostAck.
REQ-014 HostWe  in  1  host write (1) / read (0), stable while HostReq=1.
REQ-015 HostAddr  in  ADDR_W  host address, stable while HostReq=1.
REQ-016 HostWrData  in  DATA_W  host write data, stable while HostReq=1.
REQ-017 HostAck  out  1  one-cycle completion pulse; read data valid in the same cycle.
REQ-018 HostRdData  out  DATA_W  host read data, valid when HostAck=1.
REQ-019 MemEn, MemWe  out  1 each  synchronous single-port RAM enable/write-enable.
REQ-020 MemAddr  out  ADDR_W; MemWrData  out  DATA_W; MemRdData  in  DATA_W (valid 1 cycle after MemEn with MemWe=0).

Function
REQ-021 Arbiter SHALL grant at most one requester per cycle; grant decision combinational from current requests and registered state.
REQ-022 Default priority SHALL be CPU over host.
REQ-023 CPU request = CpuRd|CpuWr; if both high, SHALL treat as write.
REQ-024 Granted requester's address/data/we SHALL drive Mem* in the grant cycle; MemEn=0 when no grant.
REQ-025 CpuStall SHALL equal CPU request AND NOT CPU grant; CPU holds request while stalled.
REQ-026 CPU write completes in grant cycle; CPU read SHALL assert CpuRdValid exactly one cycle after grant with CpuRdData=MemRdData.
REQ-027 FSM states: IDLE, HOST_ACK; host granted in IDLE -> HOST_ACK; HOST_ACK -> IDLE unconditionally after one cycle.
REQ-028 In HOST_ACK, HostAck=1 and HostRdData=MemRdData (don't-care for writes); host SHALL NOT be re-granted in HOST_ACK; CPU may be granted in HOST_ACK.
REQ-029 Host may drop HostReq in the Ack cycle; HostReq high in the cycle after Ack SHALL be a new transaction.
REQ-030 HostReq deasserted before Ack (protocol violation) SHALL leave no pending state; no Ack issued if not yet granted.
REQ-031 Back-to-back CPU reads SHALL sustain one per cycle with zero stall when host idle.

Reset
REQ-032 Reset SHALL force FSM=IDLE, wait counter=0, and outputs CpuRdValid=0, HostAck=0, CpuStall=0, MemEn=0, MemWe=0, MemAddr=0, MemWrData=0, CpuRdData=0, HostRdData=0 while asserted.
REQ-033 Reset mid-transaction SHALL drop any pending CpuRdValid/HostAck; no pulse after release.

Configuration
REQ-034 Macro HOST_STARVE_GUARD_EN defined: counter increments each cycle HostReq=1 and host not granted, clears on host grant; when counter reaches HOST_MAX_WAIT, host SHALL win the next arbitration (CPU stalled one cycle).
REQ-035 Macro undefined: strict CPU priority, no counter logic; host may starve indefinitely.

Structure
REQ-036 Package bip_mem_pkg SHALL hold ADDR_W/DATA_W defaults and the arbiter state enum type.
REQ-037 Single module; no sub-module (counter inline).

Verification
REQ-038 Idle: CpuWr=1, CpuAddr=0x005, CpuWrData=0x1234 -> MemEn=1, MemWe=1, MemAddr=0x005 same cycle, CpuStall=0.
REQ-039 CPU read 0x005 with RAM holding 0x1234 -> CpuRdValid=1, CpuRdData=0x1234 next cycle.
REQ-040 HostReq read 0x00A (RAM=0xBEEF), CPU idle -> grant cycle N, HostAck=1, HostRdData=0xBEEF at N+1, HostAck=0 at N+2.
REQ-041 CPU and host request same cycle -> CPU granted, host waits; CPU drops -> host granted next cycle.
REQ-042 With HOST_STARVE_GUARD_EN, CPU requesting continuously, host requesting -> host granted on cycle HOST_MAX_WAIT+1 (9 by default), CpuStall=1 that cycle only; without macro host never granted.
REQ-043 Reset asserted in HOST_ACK cycle -> HostAck=0 immediately, FSM=IDLE, no Ack after release.

Source files
------------

// File: rtl/bip_mem_pkg.sv
// Shared defaults and arbiter state type for the data-memory port of the CPU.
package bip_mem_pkg;
  localparam int ADDR_W_DEF        = 11;
  localparam int DATA_W_DEF        = 16;
  localparam int HOST_MAX_WAIT_DEF = 8;

  typedef enum logic {
    IDLE     = 1'b0,
    HOST_ACK = 1'b1
  } arb_state_t;
endpackage

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter: CPU has priority, host (debug/loader) gets the leftovers.
// Define HOST_STARVE_GUARD_EN to force a host grant after HOST_MAX_WAIT lost cycles.
module data_mem_arbiter
  import bip_mem_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int HOST_MAX_WAIT = HOST_MAX_WAIT_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CpuRd,
  input  logic              CpuWr,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [DATA_W-1:0] CpuWrData,
  output logic [DATA_W-1:0] CpuRdData,
  output logic              CpuRdValid,
  output logic              CpuStall,
  input  logic              HostReq,
  input  logic              HostWe,
  input  logic [ADDR_W-1:0] HostAddr,
  input  logic [DATA_W-1:0] HostWrData,
  output logic              HostAck,
  output logic [DATA_W-1:0] HostRdData,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  input  logic [DATA_W-1:0] MemRdData,
  output logic              dbg_state
);

  // Handshake: CPU presents Rd/Wr and holds them while CpuStall=1; host holds
  // HostReq and its operands until the one-cycle HostAck pulse.

  arb_state_t state, state_next;
  logic       cpu_req;
  logic       cpu_grant;
  logic       host_eligible;
  logic       host_grant;
  logic       host_force;
  logic       rd_valid;

  assign cpu_req       = CpuRd | CpuWr;
  assign host_eligible = HostReq && (state == IDLE);

`ifdef HOST_STARVE_GUARD_EN
  logic [7:0] wait_cnt;

  assign host_force = (wait_cnt == 8'(HOST_MAX_WAIT));

  // Counts consecutive lost arbitrations; a dropped request leaves nothing behind.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
    end else if (host_grant || !host_eligible) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  assign host_force = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      rd_valid <= cpu_grant && !CpuWr;
    end
  end

  // Reset gates the combinational grant path so Mem*/CpuStall read zero while asserted.
  always_comb begin
    host_grant = 1'b0;
    cpu_grant  = 1'b0;
    state_next = IDLE;
    MemEn      = 1'b0;
    MemWe      = 1'b0;
    MemAddr    = '0;
    MemWrData  = '0;
    CpuStall   = 1'b0;
    if (!Reset) begin
      host_grant = host_eligible && (!cpu_req || host_force);
      cpu_grant  = cpu_req && !host_grant;
      CpuStall   = cpu_req && !cpu_grant;
      if (host_grant) begin
        state_next = HOST_ACK;
        MemEn      = 1'b1;
        MemWe      = HostWe;
        MemAddr    = HostAddr;
        MemWrData  = HostWrData;
      end else if (cpu_grant) begin
        MemEn      = 1'b1;
        MemWe      = CpuWr;
        MemAddr    = CpuAddr;
        MemWrData  = CpuWrData;
      end
    end
  end

  assign CpuRdValid = rd_valid;
  assign CpuRdData  = rd_valid ? MemRdData : '0;
  assign HostAck    = (state == HOST_ACK);
  assign HostRdData = HostAck ? MemRdData : '0;
  assign dbg_state  = state;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus randomized checks of data_mem_arbiter against a cycle-level reference model.
module tb_data_mem_arbiter;
  localparam int AW  = 11;
  localparam int DW  = 16;
  localparam int MAX = 8;
`ifdef HOST_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data, cpu_rd_data;
  logic          cpu_rd_valid, cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wr_data, host_rd_data;
  logic          host_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic          dbg_state;

  int n_vec = 0;
  int n_err = 0;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_MAX_WAIT(MAX)) dut (
    .Clock(clk), .Reset(rst),
    .CpuRd(cpu_rd), .CpuWr(cpu_wr), .CpuAddr(cpu_addr), .CpuWrData(cpu_wr_data),
    .CpuRdData(cpu_rd_data), .CpuRdValid(cpu_rd_valid), .CpuStall(cpu_stall),
    .HostReq(host_req), .HostWe(host_we), .HostAddr(host_addr), .HostWrData(host_wr_data),
    .HostAck(host_ack), .HostRdData(host_rd_data),
    .MemEn(mem_en), .MemWe(mem_we), .MemAddr(mem_addr), .MemWrData(mem_wr_data),
    .MemRdData(mem_rd_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Synchronous single-port RAM attached to the Mem* port.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q = '0;
  assign mem_rd_data = ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wr_data;
      else        ram_q <= ram[mem_addr];
    end
  end

  // ---------------- checker / drivers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic host_set(input logic req, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    host_req = req; host_we = we; host_addr = a; host_wr_data = d;
  endtask

  // ---------------- reference model state ----------------
  logic [DW-1:0] ref_mem [0:15];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] host_exp;
  bit  cpu_req_m, host_elig, host_win, cpu_win;
  bit  ack_cycle, host_rd_op, rd_pend;
  int  waited;
  int  op;

  initial begin
    rst = 1'b1;
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 11'h005; cpu_wr_data = 16'h1234;
    host_set(1'b0, 1'b0, '0, '0);

    // Reset: outputs quiet even with a CPU request present.
    @(negedge clk);
    chk("rst_mem_en",   mem_en, 0);
    chk("rst_mem_we",   mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd",   mem_wr_data, 0);
    chk("rst_stall",    cpu_stall, 0);
    chk("rst_rd_valid", cpu_rd_valid, 0);
    chk("rst_rd_data",  cpu_rd_data, 0);
    chk("rst_host_ack", host_ack, 0);
    chk("rst_host_rd",  host_rd_data, 0);
    chk("rst_state",    dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // CPU write at idle drives the RAM in the same cycle.
    @(negedge clk);
    chk("wr_mem_en",   mem_en, 1);
    chk("wr_mem_we",   mem_we, 1);
    chk("wr_mem_addr", mem_addr, 11'h005);
    chk("wr_mem_wd",   mem_wr_data, 16'h1234);
    chk("wr_stall",    cpu_stall, 0);
    tick();

    // CPU read returns data the following cycle.
    cpu_wr = 1'b0; cpu_rd = 1'b1;
    @(negedge clk);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_we", mem_we, 0);
    tick();
    cpu_idle();
    @(negedge clk);
    chk("rd_valid", cpu_rd_valid, 1);
    chk("rd_data",  cpu_rd_data, 16'h1234);
    tick();
    @(negedge clk);
    chk("rd_valid_pulse", cpu_rd_valid, 0);

    cpu_wr = 1'b1; cpu_addr = 11'h00A; cpu_wr_data = 16'hBEEF;
    tick();
    cpu_idle();

    // Host read with the CPU idle: grant N, ack N+1, quiet N+2.
    host_set(1'b1, 1'b0, 11'h00A, 16'h0);
    @(negedge clk);
    chk("host_grant_en",   mem_en, 1);
    chk("host_grant_addr", mem_addr, 11'h00A);
    chk("host_grant_ack",  host_ack, 0);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    chk("host_ack",      host_ack, 1);
    chk("host_rd_data",  host_rd_data, 16'hBEEF);
    chk("host_ack_st",   dbg_state, 1);
    tick();
    @(negedge clk);
    chk("host_ack_pulse", host_ack, 0);
    tick();

    // Same-cycle contention: CPU first, host the cycle the CPU lets go.
    cpu_rd = 1'b1; cpu_addr = 11'h005;
    host_set(1'b1, 1'b0, 11'h00A, 16'h0);
    @(negedge clk);
    chk("cont_cpu_addr", mem_addr, 11'h005);
    chk("cont_stall",    cpu_stall, 0);
    tick();
    cpu_idle();
    @(negedge clk);
    chk("cont_host_addr", mem_addr, 11'h00A);
    chk("cont_host_en",   mem_en, 1);
    chk("cont_cpu_data",  cpu_rd_data, 16'h1234);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    chk("cont_host_ack",  host_ack, 1);
    chk("cont_host_data", host_rd_data, 16'hBEEF);
    tick(); tick();

    // Continuous CPU traffic: host wins only via the starvation guard.
    cpu_rd = 1'b1; cpu_addr = 11'h005;
    host_set(1'b1, 1'b0, 11'h00A, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("starve_stall_%0d", k), cpu_stall, GUARD && (k == MAX + 1));
      chk($sformatf("starve_ack_%0d", k),   host_ack,  GUARD && (k == MAX + 2));
      tick();
    end
    cpu_idle();
    host_req = 1'b0;
    tick(); tick();

    // Reset during the ack cycle kills the pulse and does not bring it back.
    host_set(1'b1, 1'b0, 11'h00A, 16'h0);
    tick();
    host_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ack_now",   host_ack, 0);
    chk("rst_ack_state", dbg_state, 0);
    chk("rst_ack_data",  host_rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_ack_after", host_ack, 0);
      tick();
    end

    // Host abandons a request before grant: nothing is left pending.
    cpu_rd = 1'b1; cpu_addr = 11'h005;
    host_set(1'b1, 1'b0, 11'h00A, 16'h0);
    tick();
    host_req = 1'b0;
    @(negedge clk);
    chk("abandon_cpu_addr", mem_addr, 11'h005);
    tick();
    cpu_idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abandon_ack", host_ack, 0);
      chk("abandon_en",  mem_en, 0);
      tick();
    end

    // Preload a small known region for the model.
    for (int i = 0; i < 16; i++) begin
      cpu_wr = 1'b1; cpu_addr = AW'(i); cpu_wr_data = DW'($urandom);
      ref_mem[i] = cpu_wr_data;
      tick();
    end
    cpu_idle();

    // Back-to-back reads: one per cycle, no stalls.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin cpu_rd = 1'b1; cpu_addr = AW'(i); end
      else cpu_idle();
      @(negedge clk);
      if (i < 8) chk("b2b_stall", cpu_stall, 0);
      if (i > 0) begin
        chk("b2b_valid", cpu_rd_valid, 1);
        chk("b2b_data",  cpu_rd_data, ref_mem[i-1]);
      end
      tick();
    end
    tick();

    // Randomized traffic against the reference model.
    waited = 0; ack_cycle = 0; rd_pend = 0; host_rd_op = 0; host_exp = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      cpu_req_m = cpu_rd | cpu_wr;
      host_elig = host_req && !ack_cycle;
      host_win  = host_elig && (!cpu_req_m || (GUARD && waited >= MAX));
      cpu_win   = cpu_req_m && !host_win;
      chk("rnd_mem_en", mem_en, cpu_req_m || host_win);
      chk("rnd_stall",  cpu_stall, cpu_req_m && host_win);
      chk("rnd_addr",   mem_addr, host_win ? host_addr : (cpu_win ? cpu_addr : '0));
      chk("rnd_we",     mem_we, host_win ? host_we : (cpu_win ? cpu_wr : 1'b0));
      chk("rnd_rd_valid", cpu_rd_valid, rd_pend);
      if (rd_pend && exp_q.size() > 0) chk("rnd_rd_data", cpu_rd_data, exp_q.pop_front());
      chk("rnd_host_ack", host_ack, ack_cycle);
      if (ack_cycle && host_rd_op) chk("rnd_host_data", host_rd_data, host_exp);

      rd_pend = cpu_win && !cpu_wr;
      if (cpu_win) begin
        if (cpu_wr) ref_mem[cpu_addr[3:0]] = cpu_wr_data;
        else        exp_q.push_back(ref_mem[cpu_addr[3:0]]);
      end
      if (host_win) begin
        host_rd_op = !host_we;
        if (host_we) ref_mem[host_addr[3:0]] = host_wr_data;
        else         host_exp = ref_mem[host_addr[3:0]];
      end
      waited    = host_win ? 0 : (host_elig ? waited + 1 : 0);
      ack_cycle = host_win;
      tick();

      if (!cpu_req_m || cpu_win) begin
        op = $urandom_range(0, 4);
        cpu_rd = (op == 2) || (op == 4);
        cpu_wr = (op == 3) || (op == 4);
        cpu_addr = AW'($urandom_range(0, 15));
        cpu_wr_data = DW'($urandom);
      end
      if (host_win) host_req = 1'b0;
      if (!host_req && !ack_cycle && $urandom_range(0, 3) == 0)
        host_set(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
